ball_engine: RTL and testbench

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine_if.sv | 28 ++
 rtl/ball_engine.sv | 145 ++++++++++++++
 tb/tb_ball_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_engine_if.sv
// Ball engine control/status bundle: serve and paddle inputs in, ball position,
// speed and miss pulses out. The engine takes the slave side.
interface ball_engine_if #(
  parameter int X_WIDTH     = 6,
  parameter int Y_WIDTH     = 5,
  parameter int SPEED_WIDTH = 4
);
  logic                   serve;
  logic                   serveRight;
  logic                   isHittingLeft;
  logic                   isHittingRight;
  logic [X_WIDTH-1:0]     xPosition;
  logic [Y_WIDTH-1:0]     yPosition;
  logic [SPEED_WIDTH-1:0] speed;
  logic                   moving;
  logic                   missLeft;
  logic                   missRight;

  modport master (
    output serve, serveRight, isHittingLeft, isHittingRight,
    input  xPosition, yPosition, speed, moving, missLeft, missRight
  );

  modport slave (
    input  serve, serveRight, isHittingLeft, isHittingRight,
    output xPosition, yPosition, speed, moving, missLeft, missRight
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: rate-accumulated diagonal stepping with wall/paddle bounces and miss detection.
// Optional BALL_SPEEDUP_EN: each paddle reversal bumps speed by one, saturating.
module ball_engine #(
  parameter int X_WIDTH     = 6,
  parameter int Y_WIDTH     = 5,
  parameter int SPEED_WIDTH = 4,
  parameter int TICK_LIMIT  = 500000,
  parameter int X_START     = 8,
  parameter int Y_START     = 4
) (
  input logic          clk,
  input logic          reset,
  ball_engine_if.slave bus
);
  localparam int ACC_WIDTH = $clog2(TICK_LIMIT + 2**SPEED_WIDTH);

  localparam logic [ACC_WIDTH-1:0]   TICK    = ACC_WIDTH'(TICK_LIMIT);
  localparam logic [X_WIDTH-1:0]     X_INIT  = X_WIDTH'(X_START);
  localparam logic [Y_WIDTH-1:0]     Y_INIT  = Y_WIDTH'(Y_START);
  localparam logic [X_WIDTH-1:0]     X_ONE   = X_WIDTH'(1);
  localparam logic [X_WIDTH-1:0]     X_NEAR  = X_WIDTH'(2**X_WIDTH - 2);
  localparam logic [Y_WIDTH-1:0]     Y_TOP   = Y_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]     Y_BOT   = Y_WIDTH'(2**Y_WIDTH - 2);
  localparam logic [SPEED_WIDTH-1:0] SPD_ONE = SPEED_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    MISSED = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [X_WIDTH-1:0]     x, x_n;
  logic [Y_WIDTH-1:0]     y, y_n;
  logic [SPEED_WIDTH-1:0] spd, spd_n;
  logic [ACC_WIDTH-1:0]   acc, acc_n;
  logic                   xdir, xdir_n;   // 1 = right
  logic                   ydir, ydir_n;   // 1 = down (increasing y)
  logic                   miss_l, miss_l_n;
  logic                   miss_r, miss_r_n;

  logic [ACC_WIDTH-1:0]   sum;
  logic                   xdir_s, ydir_s, hit;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    spd_n    = spd;
    acc_n    = acc;
    xdir_n   = xdir;
    ydir_n   = ydir;
    miss_l_n = 1'b0;
    miss_r_n = 1'b0;
    sum      = acc + ACC_WIDTH'(spd);
    xdir_s   = xdir;
    ydir_s   = ydir;
    hit      = 1'b0;

    unique case (state)
      IDLE, MISSED: begin
        if (bus.serve) begin
          state_n = MOVE;
          x_n     = X_INIT;
          y_n     = Y_INIT;
          spd_n   = SPD_ONE;
          acc_n   = '0;
          xdir_n  = bus.serveRight;
          ydir_n  = 1'b1;
        end
      end
      MOVE: begin
        if (sum >= TICK) begin
          acc_n = sum - TICK;
          // Reversals are resolved before the move so a bounce never lands on a wall row/column.
          if (y == Y_TOP && !ydir)     ydir_s = 1'b1;
          else if (y == Y_BOT && ydir) ydir_s = 1'b0;
          if (x == X_ONE && !xdir && bus.isHittingLeft) begin
            xdir_s = 1'b1;
            hit    = 1'b1;
          end else if (x == X_NEAR && xdir && bus.isHittingRight) begin
            xdir_s = 1'b0;
            hit    = 1'b1;
          end
          x_n    = xdir_s ? x + X_WIDTH'(1) : x - X_WIDTH'(1);
          y_n    = ydir_s ? y + Y_WIDTH'(1) : y - Y_WIDTH'(1);
          xdir_n = xdir_s;
          ydir_n = ydir_s;
          if (x_n == '0) begin
            miss_l_n = 1'b1;
            state_n  = MISSED;
          end else if (x_n == '1) begin
            miss_r_n = 1'b1;
            state_n  = MISSED;
          end
`ifdef BALL_SPEEDUP_EN
          if (hit && spd != '1) spd_n = spd + SPD_ONE;
`else
          spd_n = spd;
`endif
        end else begin
          acc_n = sum;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x      <= X_INIT;
      y      <= Y_INIT;
      spd    <= SPD_ONE;
      acc    <= '0;
      xdir   <= 1'b1;
      ydir   <= 1'b1;
      miss_l <= 1'b0;
      miss_r <= 1'b0;
    end else begin
      x      <= x_n;
      y      <= y_n;
      spd    <= spd_n;
      acc    <= acc_n;
      xdir   <= xdir_n;
      ydir   <= ydir_n;
      miss_l <= miss_l_n;
      miss_r <= miss_r_n;
    end
  end

  assign bus.xPosition = x;
  assign bus.yPosition = y;
  assign bus.speed     = spd;
  assign bus.moving    = (state == MOVE);
  assign bus.missLeft  = miss_l;
  assign bus.missRight = miss_r;

  logic unused_hit;
  assign unused_hit = hit;
endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with TICK_LIMIT=4: serve timing, wall and paddle
// bounces, misses on both sides, serve-in-MOVE rejection and mid-step reset.
module tb_ball_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ball_engine_if #(.X_WIDTH(6), .Y_WIDTH(5), .SPEED_WIDTH(4)) bus ();

  ball_engine #(
    .X_WIDTH(6), .Y_WIDTH(5), .SPEED_WIDTH(4),
    .TICK_LIMIT(4), .X_START(8), .Y_START(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

`ifdef BALL_SPEEDUP_EN
  localparam int HIT_SPEED = 2;
  localparam int X_AFTER_2 = 3;
`else
  localparam int HIT_SPEED = 1;
  localparam int X_AFTER_2 = 2;
`endif

  int checks = 0;
  int failures = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until the ball has taken n steps; a step that never arrives is a failure.
  task automatic step(input int n);
    logic [5:0] old;
    int cnt;
    for (int i = 0; i < n; i++) begin
      old = bus.xPosition;
      cnt = 0;
      do begin
        tick(1);
        cnt++;
      end while (bus.xPosition === old && cnt < 8);
      if (bus.xPosition === old) begin
        checks++;
        failures++;
        $error("FAIL step_timeout observed=%0d expected=changed", bus.xPosition);
      end
    end
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, 32'(bus.xPosition), ex);
    chk({tag, "_y"}, 32'(bus.yPosition), ey);
  endtask

  initial begin
    bus.serve = 1'b0;
    bus.serveRight = 1'b0;
    bus.isHittingLeft = 1'b0;
    bus.isHittingRight = 1'b0;

    // Reset and idle hold
    tick(2);
    reset = 1'b1;
    chk_pos("rst", 8, 4);
    chk("rst_speed", 32'(bus.speed), 1);
    chk("rst_moving", 32'(bus.moving), 0);
    chk("rst_missl", 32'(bus.missLeft), 0);
    chk("rst_missr", 32'(bus.missRight), 0);
    tick(20);
    chk_pos("idle_hold", 8, 4);
    chk("idle_moving", 32'(bus.moving), 0);

    // Serve right, step cadence every 4 cycles
    bus.serve = 1'b1;
    bus.serveRight = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    chk("serve_moving", 32'(bus.moving), 1);
    chk_pos("serve", 8, 4);
    tick(3);
    chk_pos("pre_step1", 8, 4);
    tick(1);
    chk_pos("step1", 9, 5);
    tick(3);
    chk_pos("pre_step2", 9, 5);
    tick(1);
    chk_pos("step2", 10, 6);

    // Serve while moving is ignored
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    chk_pos("serve_ign", 10, 6);
    chk("serve_ign_moving", 32'(bus.moving), 1);
    tick(3);
    chk_pos("step3", 11, 7);

    // Bottom wall bounce
    bus.isHittingRight = 1'b1;
    step(23);
    chk_pos("bottom", 34, 30);
    step(1);
    chk_pos("bottom_bounce", 35, 29);

    // Reset in the same cycle as a step
    tick(3);
    chk_pos("pre_rst_step", 35, 29);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk_pos("midrst", 8, 4);
    chk("midrst_speed", 32'(bus.speed), 1);
    chk("midrst_moving", 32'(bus.moving), 0);
    chk("midrst_missl", 32'(bus.missLeft), 0);
    chk("midrst_missr", 32'(bus.missRight), 0);
    tick(5);
    chk_pos("midrst_hold", 8, 4);

    // Serve left, left paddle hit
    bus.serveRight = 1'b0;
    bus.isHittingLeft = 1'b1;
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    step(7);
    chk_pos("left_edge", 1, 11);
    step(1);
    chk_pos("left_hit", 2, 12);
    chk("left_hit_speed", 32'(bus.speed), HIT_SPEED);
    chk("left_hit_moving", 32'(bus.moving), 1);
    tick(1);
    chk("post_hit_x1", 32'(bus.xPosition), 2);
    tick(1);
    chk("post_hit_x2", 32'(bus.xPosition), X_AFTER_2);
`ifndef BALL_SPEEDUP_EN
    tick(2);
`endif
    chk_pos("post_hit_sync", 3, 13);

    // Top wall bounce
    step(46);
    chk_pos("top", 49, 1);
    step(1);
    chk_pos("top_bounce", 50, 2);

    // Left miss, hold in MISSED, re-serve
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    bus.isHittingLeft = 1'b0;
    bus.serveRight = 1'b0;
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    step(7);
    chk_pos("lmiss_edge", 1, 11);
    step(1);
    chk_pos("lmiss", 0, 12);
    chk("lmiss_pulse", 32'(bus.missLeft), 1);
    chk("lmiss_other", 32'(bus.missRight), 0);
    chk("lmiss_moving", 32'(bus.moving), 0);
    tick(1);
    chk("lmiss_pulse_end", 32'(bus.missLeft), 0);
    bus.isHittingLeft = 1'b1;
    tick(10);
    chk_pos("missed_hold", 0, 12);
    chk("missed_moving", 32'(bus.moving), 0);
    bus.serveRight = 1'b1;
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    chk_pos("reserve", 8, 4);
    chk("reserve_speed", 32'(bus.speed), 1);
    chk("reserve_moving", 32'(bus.moving), 1);

    // Right miss
    bus.isHittingRight = 1'b0;
    step(54);
    chk_pos("rmiss_edge", 62, 2);
    step(1);
    chk_pos("rmiss", 63, 1);
    chk("rmiss_pulse", 32'(bus.missRight), 1);
    chk("rmiss_other", 32'(bus.missLeft), 0);
    chk("rmiss_moving", 32'(bus.moving), 0);
    tick(1);
    chk("rmiss_pulse_end", 32'(bus.missRight), 0);
    chk_pos("rmiss_hold", 63, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
